// File: rtl/pulse_line_framer_pkg.sv
// pulse_pkg: shared state encoding and constants for the pulse line framer.
package pulse_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      HEADER = 2'd1,
      DATA   = 2'd2
   } state_e;

   localparam logic [15:0] HEADER_MAGIC = 16'hA5A5;
   localparam logic [15:0] DROP_SAT     = 16'hFFFF;

endpackage

// File: rtl/pulse_line_fifo.sv
// pulse_line_fifo: synchronous show-ahead FIFO. rdata_o is a register that always
// holds the head word, so a pop and its data are available in the same cycle.
module pulse_line_fifo
   import pulse_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int FIFO_DEPTH = 1024
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   input  logic                  flush_i,
   input  logic                  push_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic                  pop_i,
   output logic [DATA_WIDTH-1:0] rdata_o,
   output logic                  full_o,
   output logic                  empty_o
);

   localparam int AW = $clog2(FIFO_DEPTH);

   logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
   logic [AW:0]           count_q;
   logic [DATA_WIDTH-1:0] rdata_q;
   logic                  do_push, do_pop;

   assign full_o  = (count_q == (AW+1)'(FIFO_DEPTH));
   assign empty_o = (count_q == '0);
   assign do_push = push_i & ~full_o & ~flush_i;
   assign do_pop  = pop_i & ~empty_o & ~flush_i;
   assign rdata_o = rdata_q;

   // storage array, no reset so it can map onto RAM
   always_ff @(posedge aclk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

   // pointers, occupancy and head-word register
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         rdata_q  <= '0;
      end else if (flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + (AW+1)'(1);
            2'b01:   count_q <= count_q - (AW+1)'(1);
            default: count_q <= count_q;
         endcase
         // new word becomes head when the FIFO is (or is about to be) empty
         if (do_push && (empty_o || (count_q == (AW+1)'(1) && do_pop)))
            rdata_q <= wdata_i;
         else if (do_pop)
            rdata_q <= mem_q[rd_ptr_q + AW'(1)];
      end
   end

endmodule

// File: rtl/pulse_line_framer.sv
// pulse_line_framer: buffers integrator samples and re-emits them as AXI4-Stream
// lines of cfg_line_len words with tlast on each line's last word.
// Optional feature macro PULSE_LINE_HEADER_EN: prefix each line with a header word
// {HEADER_MAGIC, line_count[15:0]}.
module pulse_line_framer
   import pulse_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int FIFO_DEPTH = 1024
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic                  m_axis_tlast,
   input  logic                  cfg_enable,
   input  logic [15:0]           cfg_line_len,
   output logic [31:0]           sts_line_count,
   output logic [15:0]           sts_drop_count,
   output logic                  sts_overflow
);

   state_e                state_q, state_d;
   logic [15:0]           len_q, len_d, cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
   logic                  tvalid_q, tvalid_d, tlast_q, tlast_d;
   logic [31:0]           line_cnt_q;
   logic [15:0]           drop_cnt_q;
   logic                  ovf_q, enable_q;
   logic                  fifo_full, fifo_empty, push, pop, drop, out_free, last_hs;
   logic [DATA_WIDTH-1:0] fifo_rdata;

   // fullness is judged before any same-cycle pop, so a push while full is dropped
   assign s_axis_tready = cfg_enable & ~fifo_full;
   assign push          = s_axis_tvalid & s_axis_tready;
   assign drop          = s_axis_tvalid & cfg_enable & fifo_full;
   assign out_free      = ~tvalid_q | m_axis_tready;
   assign last_hs       = tvalid_q & m_axis_tready & tlast_q & cfg_enable;

`ifdef PULSE_LINE_HEADER_EN
   // header must reflect a tlast handshake completing in the same cycle
   logic [31:0] lc_next;
   assign lc_next = line_cnt_q + 32'(last_hs);
`endif

   pulse_line_fifo #(
      .DATA_WIDTH(DATA_WIDTH),
      .FIFO_DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .aclk    (aclk),
      .aresetn (aresetn),
      .flush_i (~cfg_enable),
      .push_i  (push),
      .wdata_i (s_axis_tdata),
      .pop_i   (pop),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // line sequencing: decides what the output register holds next
   always_comb begin
      state_d  = state_q;
      len_d    = len_q;
      cnt_d    = cnt_q;
      tdata_d  = tdata_q;
      tvalid_d = tvalid_q;
      tlast_d  = tlast_q;
      pop      = 1'b0;
      if (!cfg_enable) begin
         state_d  = IDLE;
         cnt_d    = '0;
         tvalid_d = 1'b0;
         tlast_d  = 1'b0;
      end else if (out_free) begin
         tvalid_d = 1'b0;
         tlast_d  = 1'b0;
         case (state_q)
            IDLE: begin
               if (!fifo_empty && cfg_line_len != '0) begin
                  len_d    = cfg_line_len;
                  tvalid_d = 1'b1;
`ifdef PULSE_LINE_HEADER_EN
                  tdata_d  = DATA_WIDTH'({HEADER_MAGIC, lc_next[15:0]});
                  cnt_d    = '0;
                  state_d  = HEADER;
`else
                  pop      = 1'b1;
                  tdata_d  = fifo_rdata;
                  cnt_d    = 16'd1;
                  tlast_d  = (cfg_line_len == 16'd1);
                  state_d  = (cfg_line_len == 16'd1) ? IDLE : DATA;
`endif
               end
            end
`ifdef PULSE_LINE_HEADER_EN
            HEADER, DATA: begin
`else
            DATA: begin
`endif
               state_d = DATA;
               if (!fifo_empty) begin
                  pop      = 1'b1;
                  tdata_d  = fifo_rdata;
                  tvalid_d = 1'b1;
                  cnt_d    = cnt_q + 16'd1;
                  if (cnt_q + 16'd1 == len_q) begin
                     tlast_d = 1'b1;
                     state_d = IDLE;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // FSM and output register
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q  <= IDLE;
         len_q    <= '0;
         cnt_q    <= '0;
         tdata_q  <= '0;
         tvalid_q <= 1'b0;
         tlast_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         len_q    <= len_d;
         cnt_q    <= cnt_d;
         tdata_q  <= tdata_d;
         tvalid_q <= tvalid_d;
         tlast_q  <= tlast_d;
      end
   end

   // status: line count wraps, drops saturate, both drop stats clear on enable rise
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         enable_q   <= 1'b0;
         line_cnt_q <= '0;
         drop_cnt_q <= '0;
         ovf_q      <= 1'b0;
      end else begin
         enable_q <= cfg_enable;
         if (last_hs) line_cnt_q <= line_cnt_q + 32'd1;
         if (cfg_enable && !enable_q) begin
            drop_cnt_q <= '0;
            ovf_q      <= 1'b0;
         end else if (drop) begin
            ovf_q <= 1'b1;
            if (drop_cnt_q != DROP_SAT) drop_cnt_q <= drop_cnt_q + 16'd1;
         end
      end
   end

   assign m_axis_tdata   = tdata_q;
   assign m_axis_tvalid  = tvalid_q;
   assign m_axis_tlast   = tlast_q;
   assign sts_line_count = line_cnt_q;
   assign sts_drop_count = drop_cnt_q;
   assign sts_overflow   = ovf_q;

endmodule

// File: tb/tb_pulse_line_framer.sv
// Directed bench for pulse_line_framer (FIFO_DEPTH=4). Expected output streams are
// hand-written; header words appear only when PULSE_LINE_HEADER_EN is defined.
module tb_pulse_line_framer;

`ifdef PULSE_LINE_HEADER_EN
   localparam bit HDR = 1'b1;
`else
   localparam bit HDR = 1'b0;
`endif

   logic        aclk = 1'b0;
   logic        aresetn;
   logic [31:0] s_axis_tdata;
   logic        s_axis_tvalid;
   logic        s_axis_tready;
   logic [31:0] m_axis_tdata;
   logic        m_axis_tvalid;
   logic        m_axis_tready;
   logic        m_axis_tlast;
   logic        cfg_enable;
   logic [15:0] cfg_line_len;
   logic [31:0] sts_line_count;
   logic [15:0] sts_drop_count;
   logic        sts_overflow;

   int n_vec = 0;
   int n_err = 0;

   logic [32:0] outq[$];
   logic [32:0] expq[$];
   logic        stab_en = 1'b0;
   logic        pv = 1'b0, pr = 1'b0, pl = 1'b0;
   logic [31:0] pd = '0;

   pulse_line_framer #(.DATA_WIDTH(32), .FIFO_DEPTH(4)) dut (
      .aclk           (aclk),
      .aresetn        (aresetn),
      .s_axis_tdata   (s_axis_tdata),
      .s_axis_tvalid  (s_axis_tvalid),
      .s_axis_tready  (s_axis_tready),
      .m_axis_tdata   (m_axis_tdata),
      .m_axis_tvalid  (m_axis_tvalid),
      .m_axis_tready  (m_axis_tready),
      .m_axis_tlast   (m_axis_tlast),
      .cfg_enable     (cfg_enable),
      .cfg_line_len   (cfg_line_len),
      .sts_line_count (sts_line_count),
      .sts_drop_count (sts_drop_count),
      .sts_overflow   (sts_overflow)
   );

   always #5 aclk = ~aclk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // inputs change 1 time unit after the rising edge
   task automatic step();
      @(posedge aclk);
      #1;
   endtask

   task automatic push_seq(input int first, input int n);
      for (int i = 0; i < n; i++) begin
         s_axis_tdata  = 32'(first + i);
         s_axis_tvalid = 1'b1;
         step();
      end
      s_axis_tvalid = 1'b0;
   endtask

   task automatic ex(input bit l, input int d);
      expq.push_back({l, 32'(d)});
   endtask

   task automatic ex_hdr(input int n);
      if (HDR) expq.push_back({1'b0, 16'hA5A5, 16'(n)});
   endtask

   task automatic cmp_q(input string tag);
      logic [32:0] o;
      chk({tag, "_count"}, 64'(outq.size()), 64'(expq.size()));
      for (int i = 0; i < expq.size(); i++) begin
         o = (i < outq.size()) ? outq[i] : 'x;
         chk($sformatf("%s_w%0d", tag, i), 64'(o), 64'(expq[i]));
      end
      outq.delete();
      expq.delete();
   endtask

   task automatic check_out(input string tag);
      int c = 0;
      while (outq.size() < expq.size() && c < 300) begin
         step();
         c++;
      end
      repeat (4) step();
      cmp_q(tag);
   endtask

   // capture handshakes (valid&ready seen mid-cycle completes at the next edge)
   // and check that a stalled word is held unchanged
   always @(negedge aclk) begin
      if (aresetn && m_axis_tvalid && m_axis_tready)
         outq.push_back({m_axis_tlast, m_axis_tdata});
      if (stab_en && pv && !pr)
         chk("stall_hold", {31'd0, m_axis_tvalid, m_axis_tlast, m_axis_tdata},
             {31'd0, 1'b1, pl, pd});
      pv <= m_axis_tvalid;
      pr <= m_axis_tready;
      pl <= m_axis_tlast;
      pd <= m_axis_tdata;
   end

   initial begin
      int k;
      aresetn       = 1'b0;
      s_axis_tdata  = '0;
      s_axis_tvalid = 1'b0;
      m_axis_tready = 1'b0;
      cfg_enable    = 1'b0;
      cfg_line_len  = 16'd0;
      step();
      step();

      // reset state
      chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
      chk("rst_tlast", 64'(m_axis_tlast), 64'd0);
      chk("rst_tdata", 64'(m_axis_tdata), 64'd0);
      chk("rst_lines", 64'(sts_line_count), 64'd0);
      chk("rst_drops", 64'(sts_drop_count), 64'd0);
      chk("rst_ovf", 64'(sts_overflow), 64'd0);

      // 1: len=4, samples 1..8, tready high
      aresetn = 1'b1;
      step();
      cfg_enable    = 1'b1;
      cfg_line_len  = 16'd4;
      m_axis_tready = 1'b1;
      step();
      for (int i = 1; i <= 8; i++) begin
         push_seq(i, 1);
         step();
      end
      ex_hdr(0); ex(0, 1); ex(0, 2); ex(0, 3); ex(1, 4);
      ex_hdr(1); ex(0, 5); ex(0, 6); ex(0, 7); ex(1, 8);
      check_out("t1");
      chk("t1_lines", 64'(sts_line_count), 64'd2);

      // 2: len=3, tready toggles every cycle, stalled words must hold
      cfg_line_len = 16'd3;
      stab_en = 1'b1;
      for (int i = 0; i < 40; i++) begin
         m_axis_tready = i[0];
         if (i < 6 && !i[0]) begin
            s_axis_tdata  = 32'(i / 2 + 1);
            s_axis_tvalid = 1'b1;
         end else begin
            s_axis_tvalid = 1'b0;
         end
         step();
      end
      stab_en = 1'b0;
      m_axis_tready = 1'b1;
      ex_hdr(2); ex(0, 1); ex(0, 2); ex(1, 3);
      check_out("t2");
      chk("t2_lines", 64'(sts_line_count), 64'd3);

      // 3: overflow with stalled output, len=0 keeps the FSM out of the FIFO
      m_axis_tready = 1'b0;
      cfg_line_len  = 16'd0;
      push_seq(1, 6);
      step();
      chk("t3_drops", 64'(sts_drop_count), 64'd2);
      chk("t3_ovf", 64'(sts_overflow), 64'd1);
      chk("t3_sready", 64'(s_axis_tready), 64'd0);
      cfg_line_len  = 16'd4;
      m_axis_tready = 1'b1;
      ex_hdr(3); ex(0, 1); ex(0, 2); ex(0, 3); ex(1, 4);
      check_out("t3");
      chk("t3_lines", 64'(sts_line_count), 64'd4);

      // 4: enable drops after two data words of a four-word line
      m_axis_tready = 1'b0;
      push_seq(1, 4);
      step();
      k = HDR ? 3 : 2;
      m_axis_tready = 1'b1;
      repeat (k) step();
      m_axis_tready = 1'b0;
      step();
      ex_hdr(4); ex(0, 1); ex(0, 2);
      cmp_q("t4_part");
      chk("t4_hold_valid", 64'(m_axis_tvalid), 64'd1);
      chk("t4_hold_data", 64'(m_axis_tdata), 64'd3);
      cfg_enable = 1'b0;
      step();
      chk("t4_off_tvalid", 64'(m_axis_tvalid), 64'd0);
      chk("t4_off_tlast", 64'(m_axis_tlast), 64'd0);
      chk("t4_off_lines", 64'(sts_line_count), 64'd4);
      chk("t4_off_drops", 64'(sts_drop_count), 64'd2);
      chk("t4_off_ovf", 64'(sts_overflow), 64'd1);
      chk("t4_off_sready", 64'(s_axis_tready), 64'd0);
      push_seq(77, 1);
      step();
      cfg_enable = 1'b1;
      step();
      chk("t4_en_drops", 64'(sts_drop_count), 64'd0);
      chk("t4_en_ovf", 64'(sts_overflow), 64'd0);
      m_axis_tready = 1'b1;
      repeat (10) step();
      cmp_q("t4_flushed");

      // 5: len=0 queues samples without output, then len=2 resumes from the oldest
      cfg_line_len = 16'd0;
      push_seq(10, 3);
      repeat (10) step();
      chk("t5_idle_tvalid", 64'(m_axis_tvalid), 64'd0);
      chk("t5_idle_out", 64'(outq.size()), 64'd0);
      cfg_line_len = 16'd2;
      push_seq(13, 1);
      ex_hdr(4); ex(0, 10); ex(1, 11);
      ex_hdr(5); ex(0, 12); ex(1, 13);
      check_out("t5");
      chk("t5_lines", 64'(sts_line_count), 64'd6);

      // 6: asynchronous reset mid-line with a sample being presented
      cfg_line_len  = 16'd4;
      m_axis_tready = 1'b0;
      push_seq(1, 2);
      step();
      chk("t6_pre_tvalid", 64'(m_axis_tvalid), 64'd1);
      #2;
      aresetn       = 1'b0;
      s_axis_tdata  = 32'd99;
      s_axis_tvalid = 1'b1;
      #1;
      chk("t6_rst_tvalid", 64'(m_axis_tvalid), 64'd0);
      chk("t6_rst_tlast", 64'(m_axis_tlast), 64'd0);
      chk("t6_rst_tdata", 64'(m_axis_tdata), 64'd0);
      chk("t6_rst_lines", 64'(sts_line_count), 64'd0);
      chk("t6_rst_drops", 64'(sts_drop_count), 64'd0);
      chk("t6_rst_ovf", 64'(sts_overflow), 64'd0);
      step();
      s_axis_tvalid = 1'b0;
      aresetn       = 1'b1;
      outq.delete();
      step();
      m_axis_tready = 1'b1;
      push_seq(1, 4);
      ex_hdr(0); ex(0, 1); ex(0, 2); ex(0, 3); ex(1, 4);
      check_out("t6");
      chk("t6_lines", 64'(sts_line_count), 64'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
